mult_unsigned_seq_residue: RTL and testbench

//  Parametrised sequential unsigned multiplier (radix-2 shift-add) with mod-3 residue self-check
//  and automatic recompute-on-error. Next generation of the fault-resilient combinational 4-bit

---
 rtl/mult_unsigned_seq_residue_if.sv | 29 ++
 rtl/mult_unsigned_seq_residue.sv | 154 +++++++++++++++
 tb/tb_mult_unsigned_seq_residue.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mult_unsigned_seq_residue_if.sv
// Operand/result stream bundle for the sequential residue-checked multiplier.
// slave is the multiplier side; master is the source/consumer side.
interface mult_unsigned_seq_residue_if #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_RETRY = 2
);
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               fault_inj;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] p;
  logic               err;
  logic [RW-1:0]      retries;

  modport slave (
    input  in_valid, a, b, fault_inj, out_ready,
    output in_ready, out_valid, p, err, retries
  );

  modport master (
    output in_valid, a, b, fault_inj, out_ready,
    input  in_ready, out_valid, p, err, retries
  );
endinterface

// File: rtl/mult_unsigned_seq_residue.sv
// Radix-2 shift-add unsigned multiplier with a mod-3 residue check on the product
// and bounded recompute when the check fails.
module mult_unsigned_seq_residue #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  mult_unsigned_seq_residue_if.slave  bus
);
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_CHECK, S_DONE} state_e;

  state_e           state_q,    state_d;
  logic [WIDTH-1:0] a_hold_q,   a_hold_d;
  logic [WIDTH-1:0] b_hold_q,   b_hold_d;
  logic [PW-1:0]    mcand_q,    mcand_d;
  logic [WIDTH-1:0] mplier_q,   mplier_d;
  logic [PW-1:0]    acc_q,      acc_d;
  logic [CW-1:0]    cnt_q,      cnt_d;
  logic [RW-1:0]    retry_q,    retry_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [PW-1:0]    p_q,        p_d;
  logic             err_q,      err_d;

  logic [1:0] ra, rb, rab, rp;
  logic       res_match;

  // Bit pairs carry weight 4^k == 1 (mod 3), so summing pairs with a running fold gives the residue.
  function automatic logic [1:0] mod3(input logic [PW-1:0] v);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < int'(PW); i += 2) begin
      r = r + 3'(v[i +: 2]);
      if (r >= 3'd3) r = r - 3'd3;
    end
    return r[1:0];
  endfunction

  always_comb begin
    ra        = mod3(PW'(a_hold_q));
    rb        = mod3(PW'(b_hold_q));
    rab       = mod3(PW'({2'b00, ra} * {2'b00, rb}));
    rp        = mod3(acc_q ^ PW'(bus.fault_inj));
    res_match = (rab == rp);
  end

  always_comb begin
    state_d     = state_q;
    a_hold_d    = a_hold_q;
    b_hold_d    = b_hold_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    retry_d     = retry_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    p_d         = p_q;
    err_d       = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          a_hold_d   = bus.a;
          b_hold_d   = bus.b;
          mcand_d    = PW'(bus.a);
          mplier_d   = bus.b;
          acc_d      = '0;
          cnt_d      = CW'(WIDTH - 1);
          retry_d    = '0;
          in_ready_d = 1'b0;
          state_d    = S_CALC;
        end
      end
      S_CALC: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (res_match) begin
          p_d         = acc_q;
          err_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else if (retry_q < RW'(MAX_RETRY)) begin
          retry_d  = retry_q + RW'(1);
          acc_d    = '0;
          mcand_d  = PW'(a_hold_q);
          mplier_d = b_hold_q;
          cnt_d    = CW'(WIDTH - 1);
          state_d  = S_CALC;
        end else begin
          // Retries exhausted: report the raw accumulator and flag it untrusted.
          p_d         = acc_q;
          err_d       = 1'b1;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_hold_q    <= '0;
      b_hold_q    <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      retry_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      p_q         <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_hold_q    <= a_hold_d;
      b_hold_q    <= b_hold_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      p_q         <= p_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.p         = p_q;
  assign bus.err       = err_q;
  assign bus.retries   = retry_q;
endmodule

// File: tb/tb_mult_unsigned_seq_residue.sv
// Directed bench for mult_unsigned_seq_residue: WIDTH=4 instance for the main
// scenarios plus a WIDTH=8 instance for the full-scale product.
module tb_mult_unsigned_seq_residue;
  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   lat;
  int   stray;

  mult_unsigned_seq_residue_if #(.WIDTH(4), .MAX_RETRY(2)) bus4 ();
  mult_unsigned_seq_residue_if #(.WIDTH(8), .MAX_RETRY(2)) bus8 ();

  mult_unsigned_seq_residue #(.WIDTH(4), .MAX_RETRY(2)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  mult_unsigned_seq_residue #(.WIDTH(8), .MAX_RETRY(2)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a pair and return just after the accepting edge.
  task automatic send4(input logic [3:0] av, input logic [3:0] bv);
    int n = 0;
    bus4.a        = av;
    bus4.b        = bv;
    bus4.in_valid = 1'b1;
    while (!bus4.in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!bus4.in_ready) check_eq("accept_timeout", 32'd0, 32'd1);
    tick();
    bus4.in_valid = 1'b0;
  endtask

  // Count edges after the accepting edge until out_valid; optionally release fault_inj.
  task automatic wait_out4(input int drop_at, output int l);
    l = 0;
    while (!bus4.out_valid && l < 100) begin
      tick();
      l++;
      if (l == drop_at) bus4.fault_inj = 1'b0;
    end
    if (!bus4.out_valid) check_eq("out_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst            = 1'b1;
    bus4.in_valid  = 1'b0;
    bus4.a         = '0;
    bus4.b         = '0;
    bus4.fault_inj = 1'b0;
    bus4.out_ready = 1'b0;
    bus8.in_valid  = 1'b0;
    bus8.a         = '0;
    bus8.b         = '0;
    bus8.fault_inj = 1'b0;
    bus8.out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    check_eq("rst_in_ready",  32'(bus4.in_ready),  32'd1);
    check_eq("rst_out_valid", 32'(bus4.out_valid), 32'd0);
    check_eq("rst_p",         32'(bus4.p),         32'd0);
    check_eq("rst_err",       32'(bus4.err),       32'd0);
    check_eq("rst_retries",   32'(bus4.retries),   32'd0);

    // 15*15, fault-free latency
    bus4.out_ready = 1'b1;
    send4(4'd15, 4'd15);
    wait_out4(0, lat);
    check_eq("t1_lat",     32'(lat),          32'd5);
    check_eq("t1_p",       32'(bus4.p),       32'd225);
    check_eq("t1_err",     32'(bus4.err),     32'd0);
    check_eq("t1_retries", 32'(bus4.retries), 32'd0);
    tick();
    check_eq("t1_drop", 32'(bus4.out_valid), 32'd0);

    // zero operands back to back
    send4(4'd0, 4'd9);
    wait_out4(0, lat);
    check_eq("t2a_p",        32'(bus4.p),        32'd0);
    check_eq("t2a_lat",      32'(lat),           32'd5);
    check_eq("t2a_in_ready", 32'(bus4.in_ready), 32'd0);
    tick();
    check_eq("t2a_ready_up", 32'(bus4.in_ready), 32'd1);
    send4(4'd9, 4'd0);
    wait_out4(0, lat);
    check_eq("t2b_p",   32'(bus4.p), 32'd0);
    check_eq("t2b_lat", 32'(lat),    32'd5);
    tick();

    // consumer stall holds the result
    bus4.out_ready = 1'b0;
    send4(4'd13, 4'd11);
    wait_out4(0, lat);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("t3_hold_valid", 32'(bus4.out_valid), 32'd1);
      check_eq("t3_hold_p",     32'(bus4.p),         32'd143);
      check_eq("t3_hold_ready", 32'(bus4.in_ready),  32'd0);
    end
    check_eq("t3_err",     32'(bus4.err),     32'd0);
    check_eq("t3_retries", 32'(bus4.retries), 32'd0);
    bus4.out_ready = 1'b1;
    tick();
    check_eq("t3_one_xfer", 32'(bus4.out_valid), 32'd0);
    tick();
    check_eq("t3_no_second", 32'(bus4.out_valid), 32'd0);

    // single fault in the first check only: one recompute
    bus4.fault_inj = 1'b1;
    send4(4'd7, 4'd6);
    wait_out4(5, lat);
    check_eq("t4_lat",     32'(lat),          32'd10);
    check_eq("t4_p",       32'(bus4.p),       32'd42);
    check_eq("t4_err",     32'(bus4.err),     32'd0);
    check_eq("t4_retries", 32'(bus4.retries), 32'd1);
    tick();

    // persistent fault: retries exhausted, raw accumulator reported
    bus4.fault_inj = 1'b1;
    send4(4'd7, 4'd6);
    wait_out4(0, lat);
    bus4.fault_inj = 1'b0;
    check_eq("t5_lat",     32'(lat),          32'd15);
    check_eq("t5_p",       32'(bus4.p),       32'd42);
    check_eq("t5_err",     32'(bus4.err),     32'd1);
    check_eq("t5_retries", 32'(bus4.retries), 32'd2);
    tick();

    // reset mid-calculation aborts the operation
    send4(4'd11, 4'd13);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_eq("t6_rst_in_ready",  32'(bus4.in_ready),  32'd1);
    check_eq("t6_rst_out_valid", 32'(bus4.out_valid), 32'd0);
    check_eq("t6_rst_err",       32'(bus4.err),       32'd0);
    check_eq("t6_rst_retries",   32'(bus4.retries),   32'd0);
    rst   = 1'b0;
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus4.out_valid) stray++;
    end
    check_eq("t6_no_result", 32'(stray), 32'd0);
    send4(4'd3, 4'd5);
    wait_out4(0, lat);
    check_eq("t6_p",   32'(bus4.p), 32'd15);
    check_eq("t6_lat", 32'(lat),    32'd5);
    tick();

    // WIDTH=8 full-scale product
    bus8.out_ready = 1'b1;
    bus8.a         = 8'd255;
    bus8.b         = 8'd255;
    bus8.in_valid  = 1'b1;
    check_eq("w8_in_ready", 32'(bus8.in_ready), 32'd1);
    tick();
    bus8.in_valid = 1'b0;
    lat = 0;
    while (!bus8.out_valid && lat < 100) begin
      tick();
      lat++;
    end
    check_eq("w8_lat", 32'(lat),        32'd9);
    check_eq("w8_p",   32'(bus8.p),     32'd65025);
    check_eq("w8_err", 32'(bus8.err),   32'd0);
    tick();
    check_eq("w8_drop", 32'(bus8.out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
